controle_sensor_agua: RTL and testbench

// - Sequencer placed between the main coffee FSM and sensor_agua.
// - On a start request, runs up to N_AMOSTRAS water-level measurements, spaced INTERVALO cycles apart.
// - Each sensor timeout is retried; the block gives up after MAX_TENTATIVAS timeouts.
// - Reports one verdict per request: enough water (ok), not enough (ok=0, falha=0), or sensor failure (falha).

---
 rtl/controle_sensor_agua.sv | 163 ++++++++++++++++
 tb/tb_controle_sensor_agua.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/controle_sensor_agua.sv
// Water-level measurement sequencer between the coffee FSM and sensor_agua.
// Optional debug ports db_estado/db_amostras when CONTROLE_SENSOR_AGUA_DEBUG_EN is defined.
module controle_sensor_agua #(
  parameter int unsigned N_AMOSTRAS     = 3,
  parameter int unsigned MAX_TENTATIVAS = 2,
  parameter int unsigned INTERVALO      = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [7:0] modo_in,
  input  logic       sensor_pronto,
  input  logic       sensor_suficiente,
  input  logic       sensor_timeout,
  output logic       sensor_reset,
  output logic       sensor_medir,
  output logic       sensor_conta_timeout,
  output logic [7:0] sensor_modo,
  output logic       pronto,
  output logic       ok,
  output logic       falha
`ifdef CONTROLE_SENSOR_AGUA_DEBUG_EN
  ,
  output logic [2:0] db_estado,
  output logic [3:0] db_amostras
`endif
);

  localparam int unsigned AW = $clog2(N_AMOSTRAS + 1);
  localparam int unsigned TW = $clog2(MAX_TENTATIVAS + 1);
  localparam int unsigned IW = $clog2(INTERVALO + 1);

  typedef enum logic [2:0] {
    S_OCIOSO    = 3'd0,
    S_ZERA      = 3'd1,
    S_MEDE      = 3'd2,
    S_ESPERA    = 3'd3,
    S_AVALIA    = 3'd4,
    S_TIMEOUT   = 3'd5,
    S_INTERVALO = 3'd6,
    S_FIM       = 3'd7
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [AW-1:0] amostras_q, amostras_d, amostras_inc;
  logic [TW-1:0] tentativas_q, tentativas_d, tentativas_inc;
  logic [IW-1:0] espera_q, espera_d;
  logic          suficiente_q, suficiente_d;
  logic [7:0]    modo_q, modo_d;
  logic          ok_q, ok_d;
  logic          falha_q, falha_d;

  assign amostras_inc   = amostras_q + AW'(1);
  assign tentativas_inc = tentativas_q + TW'(1);

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= S_OCIOSO;
      amostras_q   <= '0;
      tentativas_q <= '0;
      espera_q     <= '0;
      suficiente_q <= 1'b0;
      modo_q       <= 8'h00;
      ok_q         <= 1'b0;
      falha_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      amostras_q   <= amostras_d;
      tentativas_q <= tentativas_d;
      espera_q     <= espera_d;
      suficiente_q <= suficiente_d;
      modo_q       <= modo_d;
      ok_q         <= ok_d;
      falha_q      <= falha_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    estado_d     = estado_q;
    amostras_d   = amostras_q;
    tentativas_d = tentativas_q;
    espera_d     = espera_q;
    suficiente_d = suficiente_q;
    modo_d       = modo_q;
    ok_d         = ok_q;
    falha_d      = falha_q;
    case (estado_q)
      S_OCIOSO: begin
        if (iniciar) begin
          modo_d       = modo_in;
          amostras_d   = '0;
          tentativas_d = '0;
          ok_d         = 1'b0;
          falha_d      = 1'b0;
          estado_d     = S_ZERA;
        end
      end
      S_ZERA: estado_d = S_MEDE;
      S_MEDE: estado_d = S_ESPERA;
      S_ESPERA: begin
        // A reading in the same cycle as a timeout takes priority
        if (sensor_pronto) begin
          suficiente_d = sensor_suficiente;
          estado_d     = S_AVALIA;
        end else if (sensor_timeout) begin
          estado_d = S_TIMEOUT;
        end
      end
      S_AVALIA: begin
        if (!suficiente_q) begin
          ok_d     = 1'b0;
          falha_d  = 1'b0;
          estado_d = S_FIM;
        end else begin
          amostras_d = amostras_inc;
          if (amostras_inc == AW'(N_AMOSTRAS)) begin
            ok_d     = 1'b1;
            estado_d = S_FIM;
          end else begin
            espera_d = '0;
            estado_d = S_INTERVALO;
          end
        end
      end
      S_TIMEOUT: begin
        tentativas_d = tentativas_inc;
        if (tentativas_inc == TW'(MAX_TENTATIVAS)) begin
          falha_d  = 1'b1;
          ok_d     = 1'b0;
          estado_d = S_FIM;
        end else begin
          espera_d = '0;
          estado_d = S_INTERVALO;
        end
      end
      S_INTERVALO: begin
        if (espera_q == IW'(INTERVALO - 1)) begin
          estado_d = S_ZERA;
        end else begin
          espera_d = espera_q + IW'(1);
        end
      end
      S_FIM:   estado_d = S_OCIOSO;
      default: estado_d = S_OCIOSO;
    endcase
  end

  assign sensor_reset         = (estado_q == S_ZERA);
  assign sensor_medir         = (estado_q == S_MEDE);
  assign sensor_conta_timeout = (estado_q == S_ESPERA);
  assign pronto               = (estado_q == S_FIM);
  assign sensor_modo          = modo_q;
  assign ok                   = ok_q;
  assign falha                = falha_q;

`ifdef CONTROLE_SENSOR_AGUA_DEBUG_EN
  assign db_estado   = estado_q;
  assign db_amostras = 4'(amostras_q);
`endif

endmodule

// File: tb/tb_controle_sensor_agua.sv
// Directed bench for controle_sensor_agua with a verdict scoreboard and a scripted sensor model.
module tb_controle_sensor_agua;

  localparam int unsigned N_AM = 3;
  localparam int unsigned MAX_T = 2;
  localparam int unsigned INTV = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [7:0] modo_in = 8'h00;
  logic       sensor_pronto = 1'b0;
  logic       sensor_suficiente = 1'b0;
  logic       sensor_timeout = 1'b0;
  logic       sensor_reset, sensor_medir, sensor_conta_timeout;
  logic [7:0] sensor_modo;
  logic       pronto, ok, falha;
`ifdef CONTROLE_SENSOR_AGUA_DEBUG_EN
  logic [2:0] db_estado;
  logic [3:0] db_amostras;
`endif

  int         n_vec = 0;
  int         n_bad = 0;
  logic [1:0] exp_q[$];

  controle_sensor_agua #(
    .N_AMOSTRAS(N_AM), .MAX_TENTATIVAS(MAX_T), .INTERVALO(INTV)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .modo_in(modo_in),
    .sensor_pronto(sensor_pronto), .sensor_suficiente(sensor_suficiente),
    .sensor_timeout(sensor_timeout), .sensor_reset(sensor_reset),
    .sensor_medir(sensor_medir), .sensor_conta_timeout(sensor_conta_timeout),
    .sensor_modo(sensor_modo), .pronto(pronto), .ok(ok), .falha(falha)
`ifdef CONTROLE_SENSOR_AGUA_DEBUG_EN
    ,
    .db_estado(db_estado), .db_amostras(db_amostras)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Plan codes per attempt: 0 insufficient, 1 sufficient, 2 timeout, 3 pronto+timeout together
  task automatic run_request(input string tag, input logic [7:0] modo,
                             input logic [7:0][1:0] plan, input int exp_medir,
                             input logic exp_ok, input logic exp_falha);
    int         resets = 0;
    int         medirs = 0;
    int         last_m = 0;
    int         last_off = 0;
    int         resp_at = -1;
    logic [1:0] code = 2'd0;
    logic       done = 1'b0;
    logic       modo_bad = 1'b0;
    logic [1:0] verdict;
    exp_q.push_back({exp_ok, exp_falha});
    @(negedge clock);
    iniciar = 1'b1;
    modo_in = modo;
    @(negedge clock);
    iniciar = 1'b0;
    modo_in = 8'h00;
    check({tag, " reset at k+1"}, 32'(sensor_reset), 32'd1);
    check({tag, " verdict cleared"}, 32'({ok, falha}), 32'd0);
    for (int cyc = 1; cyc < 3000 && !done; cyc++) begin
      if (cyc > 1) @(negedge clock);
      sensor_pronto     = 1'b0;
      sensor_suficiente = 1'b0;
      sensor_timeout    = 1'b0;
      if (sensor_modo !== modo) modo_bad = 1'b1;
      if (sensor_reset) resets++;
      if (sensor_medir) begin
        medirs++;
        if (medirs == 1) check({tag, " first medir cycle"}, 32'(cyc), 32'd2);
        else check({tag, " medir spacing"}, 32'(cyc - last_m), 32'(last_off + int'(INTV) + 3));
        check({tag, " reset before medir"}, 32'(resets), 32'(medirs));
        code     = (medirs <= 8) ? plan[medirs-1] : 2'd2;
        last_off = (code == 2'd2) ? 20 : 5;
        resp_at  = cyc + last_off;
        last_m   = cyc;
      end
      if (cyc == resp_at) begin
        sensor_pronto     = (code != 2'd2);
        sensor_suficiente = (code == 2'd1) || (code == 2'd3);
        sensor_timeout    = (code == 2'd2) || (code == 2'd3);
      end
      if (pronto) begin
        done = 1'b1;
        if (exp_q.size() == 0) begin
          check({tag, " unexpected verdict"}, 32'd1, 32'd0);
        end else begin
          verdict = exp_q.pop_front();
          check({tag, " ok"}, 32'(ok), 32'(verdict[1]));
          check({tag, " falha"}, 32'(falha), 32'(verdict[0]));
        end
      end
    end
    check({tag, " verdict seen"}, 32'(done), 32'd1);
    check({tag, " medir count"}, 32'(medirs), 32'(exp_medir));
    check({tag, " modo stable"}, 32'(modo_bad), 32'd0);
    @(negedge clock);
    check({tag, " verdict held"}, 32'({pronto, ok, falha}), 32'({1'b0, exp_ok, exp_falha}));
  endtask

  initial begin
    int   extra;
    logic seen;
    repeat (3) @(negedge clock);
    check("reset pulses", 32'({sensor_reset, sensor_medir, sensor_conta_timeout, pronto}), 32'd0);
    check("reset verdict", 32'({ok, falha}), 32'd0);
    check("reset modo", 32'(sensor_modo), 32'd0);
`ifdef CONTROLE_SENSOR_AGUA_DEBUG_EN
    check("reset db_estado", 32'(db_estado), 32'd0);
`endif
    reset = 1'b0;

    run_request("all good",  8'h47, 16'({2'd1, 2'd1, 2'd1}), 3, 1'b1, 1'b0);
    run_request("2nd low",   8'h50, 16'({2'd0, 2'd1}), 2, 1'b0, 1'b0);
    run_request("no answer", 8'h47, 16'({2'd2, 2'd2}), 2, 1'b0, 1'b1);
    run_request("retry ok",  8'h50, 16'({2'd1, 2'd1, 2'd1, 2'd2}), 4, 1'b1, 1'b0);
    run_request("tie",       8'h47, 16'({2'd1, 2'd1, 2'd3}), 3, 1'b1, 1'b0);

    // Abort in ESPERA with reset; no verdict may follow
    @(negedge clock);
    iniciar = 1'b1;
    modo_in = 8'h50;
    @(negedge clock);
    iniciar = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      seen = sensor_medir;
    end
    check("abort medir seen", 32'(seen), 32'd1);
    @(negedge clock);
    check("abort in espera", 32'(sensor_conta_timeout), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort idle", 32'({sensor_reset, sensor_medir, sensor_conta_timeout, pronto}), 32'd0);
    check("abort modo", 32'(sensor_modo), 32'd0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (pronto || sensor_medir || sensor_reset) extra++;
    end
    check("abort quiet", 32'(extra), 32'd0);

    run_request("after abort", 8'h47, 16'({2'd1, 2'd1, 2'd1}), 3, 1'b1, 1'b0);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
